// File: rtl/comparator_search_pkg.sv
// Shared definitions for the successive-approximation comparator search:
// state encoding, the default operand width and a flag sanity helper.
package comparator_search_pkg;

  localparam int DEFAULT_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // A healthy comparator asserts exactly one of {L,E,G}.
  function automatic logic flags_one_hot(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

endpackage

// File: rtl/comparator_search.sv
// Successive-approximation controller: drives comparator operand A and uses
// the L/E/G flags to recover the hidden operand B, MSB first, two clocks per bit.
module comparator_search
  import comparator_search_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   probe_q, probe_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               error_q, error_d;

  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   trial;
  logic [2:0]         flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    idx_d    = idx_q;
    error_d  = error_q;

    flags    = {cmp_l, cmp_e, cmp_g};
    bit_mask = WIDTH'(1) << idx_q;
    // A > B means the trial bit overshoots and must be dropped.
    trial    = cmp_g ? (probe_q & ~bit_mask) : probe_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          probe_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = IDX_W'(WIDTH - 1);
          error_d = 1'b0;
          state_d = SETTLE;
        end
      end

      SETTLE: state_d = SAMPLE;

      SAMPLE: begin
        if (!flags_one_hot(flags)) begin
          result_d = probe_q;
          error_d  = 1'b1;
          state_d  = DONE;
        end else if (cmp_e) begin
          result_d = probe_q;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          result_d = trial;
          state_d  = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          probe_d = trial | (bit_mask >> 1);
          state_d = SETTLE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done   = (state_q == DONE);
  assign probe  = probe_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_comparator_search.sv
// Directed bench for comparator_search at WIDTH=2 and WIDTH=8, each paired
// with a behavioural comparator holding a hidden B operand.
module tb_comparator_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel8;
  logic       fault_en;
  logic [1:0] b2;
  logic [7:0] b8;

  logic       start2, start8;
  logic [1:0] probe2, result2;
  logic [7:0] probe8, result8;
  logic       busy2, done2, error2, busy8, done8, error8;
  logic [2:0] flags2, flags8;

  logic [7:0] probe_m, result_m;
  logic       busy_m, done_m, error_m;

  logic [7:0] probe_log [0:63];
  int         n_checks = 0;
  int         n_fail   = 0;

  int         done_cycle;
  logic [7:0] res;
  logic       err;
  bit         busy_ok;

  always #5 clk = ~clk;

  assign start2 = start && !sel8;
  assign start8 = start && sel8;

  // Comparator models; fault_en forces an illegal L+E pattern.
  always_comb begin
    flags2 = {probe2 < b2, probe2 == b2, probe2 > b2};
    flags8 = {probe8 < b8, probe8 == b8, probe8 > b8};
    if (fault_en) begin
      flags2 = 3'b110;
      flags8 = 3'b110;
    end
  end

  assign probe_m  = sel8 ? probe8  : {6'b0, probe2};
  assign result_m = sel8 ? result8 : {6'b0, result2};
  assign busy_m   = sel8 ? busy8   : busy2;
  assign done_m   = sel8 ? done8   : done2;
  assign error_m  = sel8 ? error8  : error2;

  comparator_search #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .probe(probe2),
    .cmp_l(flags2[2]), .cmp_e(flags2[1]), .cmp_g(flags2[0]),
    .busy(busy2), .done(done2), .result(result2), .error(error2)
  );

  comparator_search #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .probe(probe8),
    .cmp_l(flags8[2]), .cmp_e(flags8[1]), .cmp_g(flags8[0]),
    .busy(busy8), .done(done8), .result(result8), .error(error8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Runs one search; returns at the negedge of the done cycle (or after a
  // 40-cycle budget with done_cycle = -1). Cycle n is observed at the negedge
  // following edge n-1, edge 0 being the one that samples start.
  task automatic applyStimulus(input bit use8, input logic [7:0] b_val,
                               input bit inject_fault, input bit poke_start,
                               output int dc, output logic [7:0] r,
                               output logic e, output bit bok);
    dc  = -1;
    bok = 1'b1;
    for (int i = 0; i < 64; i++) probe_log[i] = 8'h00;
    @(negedge clk);
    sel8     = use8;
    b2       = b_val[1:0];
    b8       = b_val;
    fault_en = inject_fault;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      probe_log[c] = probe_m;
      if (done_m) begin
        dc = c;
        if (busy_m) bok = 1'b0;
        break;
      end
      if (!busy_m) bok = 1'b0;
      if (poke_start && c == 3) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    r        = result_m;
    e        = error_m;
    fault_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel8     = 1'b0;
    fault_en = 1'b0;
    b2       = 2'b00;
    b8       = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_probe2",  {30'b0, probe2},  0);
    checkOutput("rst_result2", {30'b0, result2}, 0);
    checkOutput("rst_flags2",  {29'b0, busy2, done2, error2}, 0);
    checkOutput("rst_probe8",  {24'b0, probe8},  0);
    checkOutput("rst_result8", {24'b0, result8}, 0);
    checkOutput("rst_flags8",  {29'b0, busy8, done8, error8}, 0);
    rst = 1'b0;

    // WIDTH=2: first probe equal -> best case
    applyStimulus(0, 8'h02, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w2_b10_done",   done_cycle, 3);
    checkOutput("w2_b10_result", res, 8'h02);
    checkOutput("w2_b10_error",  err, 0);
    checkOutput("w2_b10_probe1", probe_log[1], 8'h02);

    // A start during the DONE pulse must be ignored
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("start_in_done_busy", busy2, 0);
    @(negedge clk);
    checkOutput("start_in_done_busy2", busy2, 0);

    applyStimulus(0, 8'h01, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w2_b01_done",   done_cycle, 5);
    checkOutput("w2_b01_result", res, 8'h01);
    checkOutput("w2_b01_p2",     probe_log[2], 8'h02);
    checkOutput("w2_b01_p4",     probe_log[4], 8'h01);
    checkOutput("w2_b01_busy",   busy_ok, 1);

    // Back-to-back: this start lands in the first IDLE cycle
    applyStimulus(0, 8'h00, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w2_b00_done",   done_cycle, 5);
    checkOutput("w2_b00_result", res, 8'h00);
    checkOutput("w2_b00_p4",     probe_log[4], 8'h01);

    applyStimulus(0, 8'h03, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w2_b11_done",   done_cycle, 5);
    checkOutput("w2_b11_result", res, 8'h03);
    checkOutput("w2_b11_p4",     probe_log[4], 8'h03);

    // Illegal flags at the first sample
    applyStimulus(0, 8'h01, 1, 0, done_cycle, res, err, busy_ok);
    checkOutput("fault_done",   done_cycle, 3);
    checkOutput("fault_error",  err, 1);
    checkOutput("fault_result", res, 8'h02);

    applyStimulus(0, 8'h01, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("clean_error",  err, 0);
    checkOutput("clean_result", res, 8'h01);

    // WIDTH=8
    applyStimulus(1, 8'hA5, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w8_a5_done",   done_cycle, 17);
    checkOutput("w8_a5_result", res, 8'hA5);
    checkOutput("w8_a5_busy",   busy_ok, 1);
    checkOutput("w8_a5_p2",     probe_log[2], 8'h80);
    checkOutput("w8_a5_p4",     probe_log[4], 8'hC0);

    applyStimulus(1, 8'h00, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w8_00_done",   done_cycle, 17);
    checkOutput("w8_00_result", res, 8'h00);

    applyStimulus(1, 8'h80, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("w8_80_done",   done_cycle, 3);
    checkOutput("w8_80_result", res, 8'h80);

    // Start pulse while busy is dropped, nothing queued afterwards
    applyStimulus(1, 8'hA5, 0, 1, done_cycle, res, err, busy_ok);
    checkOutput("w8_poke_done",   done_cycle, 17);
    checkOutput("w8_poke_result", res, 8'hA5);
    checkOutput("w8_poke_busy",   busy_ok, 1);
    repeat (3) @(negedge clk);
    checkOutput("w8_poke_idle", {30'b0, busy8, done8}, 0);

    // Reset in cycle 4 of a search
    @(negedge clk);
    b8    = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_probe",  probe8,  0);
    checkOutput("midrst_result", result8, 0);
    checkOutput("midrst_flags",  {29'b0, busy8, done8, error8}, 0);

    applyStimulus(1, 8'h3C, 0, 0, done_cycle, res, err, busy_ok);
    checkOutput("after_rst_done",   done_cycle, 13);
    checkOutput("after_rst_result", res, 8'h3C);
    checkOutput("after_rst_error",  err, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
